// File: rtl/qam16_pkg.sv
// Shared 16-QAM definitions: Gray level codes, the hard-decision slicer and
// the ideal constellation level used by the optional error path.
package qam16_pkg;

    typedef logic [1:0] gray_t;

    localparam gray_t GRAY_M3 = 2'b00;
    localparam gray_t GRAY_M1 = 2'b01;
    localparam gray_t GRAY_P1 = 2'b11;
    localparam gray_t GRAY_P3 = 2'b10;

    // Decision thresholds sit at -2*lvl, 0 and +2*lvl.
    function automatic gray_t slice_level(input logic signed [31:0] x,
                                          input logic signed [31:0] lvl);
        if (x >= 2 * lvl)
            return GRAY_P3;
        else if (x >= 0)
            return GRAY_P1;
        else if (x >= -2 * lvl)
            return GRAY_M1;
        else
            return GRAY_M3;
    endfunction

    function automatic logic signed [31:0] ideal_level(input gray_t code,
                                                       input logic signed [31:0] lvl);
        case (code)
            GRAY_P3: return 3 * lvl;
            GRAY_P1: return lvl;
            GRAY_M1: return -lvl;
            default: return -3 * lvl;
        endcase
    endfunction

endpackage

// File: rtl/qam16_sym_fifo.sv
// Synchronous symbol FIFO with occupancy output; a push into a full FIFO
// without a simultaneous pop is dropped and flagged in a sticky overflow bit.
module qam16_sym_fifo
    import qam16_pkg::*;
#(
    parameter int W     = 4,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [W-1:0]           din,
    input  logic                   ready,
    output logic [W-1:0]           dout,
    output logic                   valid,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]    mem [DEPTH];
    logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [LW-1:0]   level_reg;
    logic            overflow_reg;
    logic            full, empty, pop, wr_en;

    assign full  = (level_reg == LW'(DEPTH));
    assign empty = (level_reg == '0);
    assign pop   = !empty && ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign wr_en = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr_reg] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (wr_en)
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            if (wr_en && !pop)
                level_reg <= level_reg + LW'(1);
            else if (!wr_en && pop)
                level_reg <= level_reg - LW'(1);
            if (push && !wr_en)
                overflow_reg <= 1'b1;
        end
    end

    assign dout     = empty ? '0 : mem[rd_ptr_reg];
    assign valid    = !empty;
    assign level    = level_reg;
    assign overflow = overflow_reg;

endmodule

// File: rtl/qam16_symbol_slicer.sv
// Decimates matched-filter I/Q samples to one per symbol, hard-slices each rail
// to Gray-coded 16-QAM and queues symbols. Define QAM_SLICER_ERR_EN for err_i/err_q.
module qam16_symbol_slicer
    import qam16_pkg::*;
#(
    parameter int               WIDTH = 16,
    parameter int               OSR   = 4,
    parameter logic [WIDTH-1:0] LVL   = 16'h1000,
    parameter int               DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    in_valid,
    input  logic [WIDTH-1:0]        i_in,
    input  logic [WIDTH-1:0]        q_in,
    input  logic [$clog2(OSR)-1:0]  phase,
    output logic [3:0]              sym_out,
    output logic                    sym_valid,
    input  logic                    sym_ready,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    overflow
`ifdef QAM_SLICER_ERR_EN
    ,
    output logic [WIDTH-1:0]        err_i,
    output logic [WIDTH-1:0]        err_q
`endif
);
    localparam int PW = $clog2(OSR);
    localparam logic signed [31:0] LVL_S = 32'(LVL);
`ifdef QAM_SLICER_ERR_EN
    localparam int FW = 4 + 2 * WIDTH;
    localparam logic signed [31:0] ERR_MAX = (32'sd1 <<< (WIDTH - 1)) - 32'sd1;
    localparam logic signed [31:0] ERR_MIN = -(32'sd1 <<< (WIDTH - 1));
`else
    localparam int FW = 4;
`endif

    logic [PW-1:0] cnt_reg, phase_q_reg, phase_eff;
    logic          start_d_reg, rise, take;

    assign rise      = start && !start_d_reg;
    // The phase presented on the enabling cycle already governs that cycle.
    assign phase_eff = rise ? phase : phase_q_reg;
    assign take      = in_valid && start && (cnt_reg == phase_eff);

    // OSR is a power of two, so the counter wraps OSR-1 -> 0 by overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg     <= '0;
            phase_q_reg <= '0;
            start_d_reg <= 1'b0;
        end else begin
            start_d_reg <= start;
            if (!start) begin
                cnt_reg <= '0;
            end else begin
                if (rise)
                    phase_q_reg <= phase;
                if (in_valid)
                    cnt_reg <= cnt_reg + PW'(1);
            end
        end
    end

    logic signed [WIDTH-1:0] rail_in [2];
    gray_t                   code_now [2];
`ifdef QAM_SLICER_ERR_EN
    logic [WIDTH-1:0]        err_now [2];
`endif

    assign rail_in[0] = i_in;
    assign rail_in[1] = q_in;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rail
            logic signed [31:0] x_ext;
            assign x_ext        = 32'(rail_in[gi]);
            assign code_now[gi] = slice_level(x_ext, LVL_S);
`ifdef QAM_SLICER_ERR_EN
            logic signed [31:0] diff;
            assign diff        = x_ext - ideal_level(code_now[gi], LVL_S);
            assign err_now[gi] = (diff > ERR_MAX) ? ERR_MAX[WIDTH-1:0] :
                                 (diff < ERR_MIN) ? ERR_MIN[WIDTH-1:0] :
                                 diff[WIDTH-1:0];
`endif
        end
    endgenerate

    logic [FW-1:0] slice_data_next, slice_data_reg;
    logic          slice_valid_reg;

`ifdef QAM_SLICER_ERR_EN
    assign slice_data_next = {err_now[0], err_now[1], code_now[0], code_now[1]};
`else
    assign slice_data_next = {code_now[0], code_now[1]};
`endif

    always_ff @(posedge clk) begin
        if (rst || !start) begin
            slice_valid_reg <= 1'b0;
            slice_data_reg  <= '0;
        end else begin
            slice_valid_reg <= take;
            if (take)
                slice_data_reg <= slice_data_next;
        end
    end

    logic [FW-1:0] fifo_dout;

    qam16_sym_fifo #(
        .W     (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (slice_valid_reg),
        .din      (slice_data_reg),
        .ready    (sym_ready),
        .dout     (fifo_dout),
        .valid    (sym_valid),
        .level    (level),
        .overflow (overflow)
    );

    assign sym_out = fifo_dout[3:0];
`ifdef QAM_SLICER_ERR_EN
    assign err_i = fifo_dout[FW-1 -: WIDTH];
    assign err_q = fifo_dout[4 +: WIDTH];
`endif

endmodule

// File: tb/tb_qam16_symbol_slicer.sv
// Directed-plus-random bench for qam16_symbol_slicer, checked every cycle
// against a queue-based symbol model. Honours QAM_SLICER_ERR_EN.
module tb_qam16_symbol_slicer;
    localparam int          WIDTH = 16;
    localparam int          OSR   = 4;
    localparam int          DEPTH = 4;
    localparam logic [15:0] LVL   = 16'h1000;
    localparam int          L     = 4096;

    logic        clk, rst, start, in_valid, sym_ready;
    logic [15:0] i_in, q_in;
    logic [1:0]  phase;
    logic [3:0]  sym_out;
    logic        sym_valid, overflow;
    logic [2:0]  level;
`ifdef QAM_SLICER_ERR_EN
    logic [15:0] err_i, err_q;
`endif

    qam16_symbol_slicer #(
        .WIDTH (WIDTH), .OSR (OSR), .LVL (LVL), .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .i_in      (i_in),
        .q_in      (q_in),
        .phase     (phase),
        .sym_out   (sym_out),
        .sym_valid (sym_valid),
        .sym_ready (sym_ready),
        .level     (level),
        .overflow  (overflow)
`ifdef QAM_SLICER_ERR_EN
        ,
        .err_i     (err_i),
        .err_q     (err_q)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  sym;
        logic [15:0] ei;
        logic [15:0] eq;
        int          at;
    } ent_t;

    ent_t fifo_m[$];
    ent_t pend_m[$];
    bit   ovf_m, start_prev;
    int   cnt_m, ph_m, cyc;
    int   compared, mismatched;

    function automatic int lvl_of(input int x);
        if (x >= 2 * L)       return 3;
        else if (x >= 0)      return 1;
        else if (x >= -2 * L) return -1;
        else                  return -3;
    endfunction

    function automatic logic [1:0] gray(input int l);
        case (l)
            3:       return 2'b10;
            1:       return 2'b11;
            -1:      return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [15:0] errv(input int x);
        int e;
        e = x - lvl_of(x) * L;
        if (e > 32767)  e = 32767;
        if (e < -32768) e = -32768;
        return e[15:0];
    endfunction

    function automatic logic [15:0] rand_sample();
        logic [15:0] edges [10];
        edges = '{16'h2000, 16'h1FFF, 16'h0000, 16'hFFFF, 16'hE000,
                  16'hDFFF, 16'h3000, 16'hD000, 16'h7FFF, 16'h8000};
        if ($urandom_range(0, 2) == 0)
            return 16'($urandom_range(0, 65535));
        return edges[$urandom_range(0, 9)];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Symbol-level model of one clock edge: FIFO accounting, then sampling.
    task automatic model_edge();
        bit   pop, push_ok;
        ent_t arr, nw;
        int   xi, xq;
        if (rst) begin
            fifo_m.delete();
            pend_m.delete();
            ovf_m = 0; cnt_m = 0; ph_m = 0; start_prev = 0;
            return;
        end
        pop     = (fifo_m.size() > 0) && sym_ready;
        push_ok = 0;
        if (pend_m.size() > 0 && pend_m[0].at == cyc) begin
            arr = pend_m.pop_front();
            if (fifo_m.size() == DEPTH && !pop) ovf_m = 1;
            else push_ok = 1;
        end
        if (pop) void'(fifo_m.pop_front());
        if (push_ok) fifo_m.push_back(arr);
        if (start) begin
            if (!start_prev) begin
                ph_m  = int'(phase);
                cnt_m = 0;
            end
            if (in_valid) begin
                if (cnt_m == ph_m) begin
                    xi = $signed(i_in);
                    xq = $signed(q_in);
                    nw.sym = {gray(lvl_of(xi)), gray(lvl_of(xq))};
                    nw.ei  = errv(xi);
                    nw.eq  = errv(xq);
                    nw.at  = cyc + 1;
                    pend_m.push_back(nw);
                end
                cnt_m = (cnt_m + 1) % OSR;
            end
        end else begin
            cnt_m = 0;
        end
        start_prev = start;
    endtask

    task automatic check_outputs();
        chk("sym_valid", 64'(sym_valid), 64'(fifo_m.size() > 0));
        chk("level", 64'(level), 64'(fifo_m.size()));
        chk("overflow", 64'(overflow), 64'(ovf_m));
        if (fifo_m.size() > 0) begin
            chk("sym_out", 64'(sym_out), 64'(fifo_m[0].sym));
`ifdef QAM_SLICER_ERR_EN
            chk("err_i", 64'(err_i), 64'(fifo_m[0].ei));
            chk("err_q", 64'(err_q), 64'(fifo_m[0].eq));
`endif
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        check_outputs();
    endtask

    task automatic send(input logic [15:0] i, input logic [15:0] q);
        i_in = i; q_in = q; in_valid = 1'b1;
        tick();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        logic [15:0] ilist [8];
        compared = 0; mismatched = 0; cyc = 0;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; sym_ready = 1'b0;
        i_in = '0; q_in = '0; phase = '0;
        tick(); tick();
        rst = 1'b0;
        chk("reset_sym_out", 64'(sym_out), 64'h0);

        // Slicing vectors at cnt=0, phase 0
        sym_ready = 1'b1; phase = 2'd0; start = 1'b1;
        send(16'h3000, 16'hF000); send(rand_sample(), rand_sample());
        chk("slice_a", 64'(sym_out), 64'h9);
        send(rand_sample(), rand_sample()); send(rand_sample(), rand_sample());
        send(16'h2000, 16'hE000); send(rand_sample(), rand_sample());
        chk("slice_b", 64'(sym_out), 64'h9);
        send(rand_sample(), rand_sample()); send(rand_sample(), rand_sample());
        send(16'h0000, 16'hDFFF); send(rand_sample(), rand_sample());
        chk("slice_c", 64'(sym_out), 64'hC);
        send(rand_sample(), rand_sample()); send(rand_sample(), rand_sample());

        // Phase select = 2
        start = 1'b0; idle(3);
        phase = 2'd2; sym_ready = 1'b0; start = 1'b1;
        ilist = '{16'h0000, 16'h3000, 16'h1000, 16'h0000,
                  16'h0000, 16'h0000, 16'hC000, 16'h0000};
        for (int n = 0; n < 8; n++) send(ilist[n], 16'h0000);
        idle(2);
        chk("phase_level", 64'(level), 64'h2);
        chk("phase_first", 64'(sym_out), 64'hF);
        sym_ready = 1'b1; tick();
        chk("phase_second", 64'(sym_out), 64'h3);
        tick();

        // Randomized traffic with enable toggles, phase churn and resets
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 19) == 0) start = !start;
            in_valid  = ($urandom_range(0, 3) != 0);
            i_in      = rand_sample();
            q_in      = rand_sample();
            phase     = 2'($urandom_range(0, 3));
            sym_ready = ($urandom_range(0, 9) < 6);
            tick();
        end
        rst = 1'b0;

        // Full FIFO with push and pop in the same cycle
        rst = 1'b1; tick(); rst = 1'b0;
        start = 1'b0; idle(1);
        phase = 2'd0; start = 1'b1;
        for (int n = 0; n < 28; n++) begin
            sym_ready = (pend_m.size() > 0 && pend_m[0].at == cyc && fifo_m.size() == DEPTH);
            send(rand_sample(), rand_sample());
        end
        sym_ready = 1'b0;
        chk("fullpp_level", 64'(level), 64'h4);
        chk("fullpp_overflow", 64'(overflow), 64'h0);

        // Backpressure: five symbols into four slots
        rst = 1'b1; tick(); rst = 1'b0;
        start = 1'b1; phase = 2'd0; sym_ready = 1'b0;
        for (int n = 0; n < 20; n++) send(rand_sample(), rand_sample());
        idle(2);
        chk("bp_level", 64'(level), 64'h4);
        chk("bp_overflow", 64'(overflow), 64'h1);
        start = 1'b0; sym_ready = 1'b1;
        idle(4);
        chk("drain_level", 64'(level), 64'h0);
        chk("drain_overflow", 64'(overflow), 64'h1);

        // Enable gap mid-symbol; FIFO contents survive
        sym_ready = 1'b0; phase = 2'd0; start = 1'b1;
        for (int n = 0; n < 6; n++) send(rand_sample(), rand_sample());
        start = 1'b0;
        for (int n = 0; n < 3; n++) send(rand_sample(), rand_sample());
        idle(1);
        chk("gap_level", 64'(level), 64'h2);
        phase = 2'd1; start = 1'b1;
        send(16'h3000, 16'h0000);
        send(16'hD000, 16'h3000);
        idle(2);
        chk("restart_level", 64'(level), 64'h3);

        // Reset with three entries queued and overflow set
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst_valid", 64'(sym_valid), 64'h0);
        chk("rst_level", 64'(level), 64'h0);
        chk("rst_overflow", 64'(overflow), 64'h0);

`ifdef QAM_SLICER_ERR_EN
        start = 1'b0; idle(1);
        phase = 2'd0; sym_ready = 1'b0; start = 1'b1;
        send(16'h2800, 16'h0C00); send(16'h0000, 16'h0000);
        chk("err_i_2800", 64'(err_i), 64'hF800);
        chk("err_q_0C00", 64'(err_q), 64'hFC00);
        idle(2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
